// File: rtl/adder_subtractor.sv
// adder_subtractor
//
// Purpose:
//   Parameterised two's-complement adder/subtractor built as a ripple chain
//   of WIDTH full-adder stages. S selects A+B (S=0) or A-B (S=1). Subtraction
//   is done as A + ~B + 1 by inverting B and feeding S in as the carry-in.
//   The result and flags are available combinationally, and a registered
//   copy is captured on every rising clock edge for pipelined users.
//
// Ports:
//   clk       in   1      rising-edge clock for the registered outputs
//   rst       in   1      asynchronous active-high reset (registered outputs only)
//   A         in   WIDTH  first operand (minuend when subtracting)
//   B         in   WIDTH  second operand (subtrahend when subtracting)
//   S         in   1      mode: 0 = add, 1 = subtract
//   ANSWER    out  WIDTH  combinational result, wraps modulo 2^WIDTH
//   COUT      out  1      carry out of the MSB stage (subtract: 1 = no borrow)
//   OVF       out  1      signed overflow, carry into MSB XOR carry out of MSB
//   ANSWER_R  out  WIDTH  registered ANSWER
//   COUT_R    out  1      registered COUT
//   OVF_R     out  1      registered OVF

module adder_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] ANSWER,
  output logic             COUT,
  output logic             OVF,
  output logic [WIDTH-1:0] ANSWER_R,
  output logic             COUT_R,
  output logic             OVF_R
);

  // Operand B after conditional inversion for subtraction.
  logic [WIDTH-1:0] bEff;
  // carryChain[i] is the carry into stage i; carryChain[WIDTH] is the carry out.
  logic [WIDTH:0]   carryChain;
  logic [WIDTH-1:0] sumBits;

  logic [WIDTH-1:0] answer_d, answer_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  // Inverting B and injecting S as the carry-in turns the adder into A + ~B + 1.
  assign bEff = B ^ {WIDTH{S}};

  // Ripple chain of full-adder stages, evaluated LSB first so each stage
  // sees the carry produced by the one below it.
  always_comb begin
    carryChain    = '0;
    sumBits       = '0;
    carryChain[0] = S;
    for (int i = 0; i < WIDTH; i++) begin
      sumBits[i]      = A[i] ^ bEff[i] ^ carryChain[i];
      carryChain[i+1] = (A[i] & bEff[i]) | (carryChain[i] & (A[i] ^ bEff[i]));
    end
  end

  // Signed overflow shows up as a disagreement between the carry into the
  // sign bit and the carry out of it.
  assign answer_d = sumBits;
  assign cout_d   = carryChain[WIDTH];
  assign ovf_d    = carryChain[WIDTH] ^ carryChain[WIDTH-1];

  assign ANSWER = answer_d;
  assign COUT   = cout_d;
  assign OVF    = ovf_d;

  // Registered copy of the result and flags. Reset clears them at once and
  // takes priority over a coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      answer_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      answer_q <= answer_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ANSWER_R = answer_q;
  assign COUT_R   = cout_q;
  assign OVF_R    = ovf_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// Testbench for adder_subtractor: directed cases, exhaustive combinational
// sweep and randomized registered-path checks against an arithmetic model.

module tb_adder_subtractor;

  localparam int W   = 6;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         S;
  logic [W-1:0] ANSWER;
  logic         COUT;
  logic         OVF;
  logic [W-1:0] ANSWER_R;
  logic         COUT_R;
  logic         OVF_R;

  int compared;
  int mismatched;

  adder_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .S        (S),
    .ANSWER   (ANSWER),
    .COUT     (COUT),
    .OVF      (OVF),
    .ANSWER_R (ANSWER_R),
    .COUT_R   (COUT_R),
    .OVF_R    (OVF_R)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic: wrapped result, unsigned
  // carry/no-borrow, and signed range check on the true signed result.
  task automatic refModel(input int s, input int a, input int b,
                          output int ans, output int cout, output int ovf);
    int sa, sb, sr, ur;
    sa = (a >= MOD / 2) ? a - MOD : a;
    sb = (b >= MOD / 2) ? b - MOD : b;
    if (s == 0) begin
      ur   = a + b;
      sr   = sa + sb;
      cout = (ur >= MOD) ? 1 : 0;
    end else begin
      ur   = a - b;
      sr   = sa - sb;
      cout = (a >= b) ? 1 : 0;
    end
    ans = ((ur % MOD) + MOD) % MOD;
    ovf = (sr > MOD / 2 - 1 || sr < -(MOD / 2)) ? 1 : 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    S = s;
    A = a;
    B = b;
    #2;
  endtask

  task automatic checkComb(input string tag, input int ans, input int cout,
                           input int ovf);
    checkOutput({tag, ".ANSWER"}, 32'(ANSWER), ans);
    checkOutput({tag, ".COUT"},   32'(COUT),   cout);
    checkOutput({tag, ".OVF"},    32'(OVF),    ovf);
  endtask

  task automatic checkReg(input string tag, input int ans, input int cout,
                          input int ovf);
    checkOutput({tag, ".ANSWER_R"}, 32'(ANSWER_R), ans);
    checkOutput({tag, ".COUT_R"},   32'(COUT_R),   cout);
    checkOutput({tag, ".OVF_R"},    32'(OVF_R),    ovf);
  endtask

  initial begin
    int eAns, eCout, eOvf;
    int ra, rb, rs;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    S   = 1'b0;
    A   = '0;
    B   = '0;
    #1;

    // Registered outputs held at zero by reset.
    checkReg("reset", 0, 0, 0);

    // Directed combinational cases, rst still high.
    applyStimulus(1'b1, 6'd10, 6'd57);
    checkComb("sub10_57", 17, 0, 0);
    applyStimulus(1'b0, 6'd10, 6'd57);
    checkComb("add10_57", 3, 1, 0);
    applyStimulus(1'b0, 6'd31, 6'd1);
    checkComb("add31_1", 32, 0, 1);
    applyStimulus(1'b1, 6'd32, 6'd1);
    checkComb("sub32_1", 31, 1, 1);
    applyStimulus(1'b1, 6'd0, 6'd1);
    checkComb("sub0_1", 63, 0, 0);
    applyStimulus(1'b1, 6'd45, 6'd45);
    checkComb("sub45_45", 0, 1, 0);
    checkReg("resetHeld", 0, 0, 0);

    // Registered path: one edge after release, then async reset mid-cycle.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 6'd10, 6'd57);
    @(posedge clk);
    #1;
    checkReg("regCapture", 17, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkReg("asyncReset", 0, 0, 0);
    checkOutput("combDuringReset.ANSWER", 32'(ANSWER), 17);

    // Exhaustive combinational sweep.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < MOD; a++) begin
        for (int b = 0; b < MOD; b++) begin
          applyStimulus(s[0], a[W-1:0], b[W-1:0]);
          refModel(s, a, b, eAns, eCout, eOvf);
          checkComb($sformatf("sweep s%0d a%0d b%0d", s, a, b), eAns, eCout, eOvf);
        end
      end
    end

    // Randomized registered-path checks.
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rs = int'($urandom_range(1, 0));
      ra = int'($urandom_range(MOD - 1, 0));
      rb = int'($urandom_range(MOD - 1, 0));
      applyStimulus(rs[0], ra[W-1:0], rb[W-1:0]);
      refModel(rs, ra, rb, eAns, eCout, eOvf);
      @(posedge clk);
      #1;
      checkReg($sformatf("rand%0d s%0d a%0d b%0d", n, rs, ra, rb), eAns, eCout, eOvf);
    end

    // Inputs change after the edge: registered copy must hold until next edge.
    applyStimulus(1'b0, 6'd31, 6'd1);
    checkComb("postEdgeComb", 32, 0, 1);
    checkReg("holdBetweenEdges", eAns, eCout, eOvf);
    @(posedge clk);
    #1;
    checkReg("nextEdge", 32, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
